// File: rtl/prim_assembly_ctrl.sv
// Primitive assembly controller: groups BEGIN/VERTEX/END command streams into
// point, line, triangle and triangle-strip primitives for a downstream GPU stage.
module prim_assembly_ctrl #(
   parameter int VTX_W = 30
) (
   input  logic             I_CLOCK,
   input  logic             I_RESET_N,
   input  logic             I_Cmd_Valid,
   input  logic [1:0]       I_Cmd_Op,
   input  logic [1:0]       I_PrimType,
   input  logic [VTX_W-1:0] I_Vertex,
   input  logic             I_GPUStallSignal,
   output logic             O_Cmd_Ready,
   output logic             O_Prim_Valid,
   output logic [VTX_W-1:0] O_VertexV1,
   output logic [VTX_W-1:0] O_VertexV2,
   output logic [VTX_W-1:0] O_VertexV3,
   output logic [1:0]       O_PrimType,
   output logic             O_Error,
   output logic [15:0]      O_PrimCount
);

   typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_t;

   localparam logic [1:0] OP_BEGIN  = 2'b01;
   localparam logic [1:0] OP_VERTEX = 2'b10;
   localparam logic [1:0] OP_END    = 2'b11;

   state_t           state_q;
   logic [1:0]       type_q;
   logic [1:0]       idx_q;
   logic             primed_q;
   logic [VTX_W-1:0] slot_q [2];
   logic             valid_q;
   logic [VTX_W-1:0] v1_q, v2_q, v3_q;
   logic [1:0]       otype_q;
   logic             err_q;
   logic [15:0]      prim_count_q;

   logic             accept;
   logic [1:0]       need_d;
   logic [1:0]       idx_d;
   logic             done_d;

   assign O_Cmd_Ready = (state_q != ISSUE);
   assign accept      = I_Cmd_Valid & O_Cmd_Ready;

   // A primed strip completes a triangle with every vertex; otherwise the count
   // of collected vertices must reach the primitive's size.
   always_comb begin
      need_d = 2'd3;
      case (type_q)
         2'd0:    need_d = 2'd1;
         2'd1:    need_d = 2'd2;
         default: need_d = 2'd3;
      endcase
      idx_d  = idx_q + 2'd1;
      done_d = primed_q | (idx_d == need_d);
   end

   always_ff @(negedge I_CLOCK) begin
      if (!I_RESET_N) begin
         state_q      <= IDLE;
         type_q       <= 2'd0;
         idx_q        <= 2'd0;
         primed_q     <= 1'b0;
         slot_q[0]    <= '0;
         slot_q[1]    <= '0;
         valid_q      <= 1'b0;
         v1_q         <= '0;
         v2_q         <= '0;
         v3_q         <= '0;
         otype_q      <= 2'd0;
         err_q        <= 1'b0;
         prim_count_q <= 16'd0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (I_Cmd_Op == OP_BEGIN) begin
                     type_q   <= I_PrimType;
                     idx_q    <= 2'd0;
                     primed_q <= 1'b0;
                     state_q  <= COLLECT;
                  end else if (I_Cmd_Op != 2'b00) begin
                     err_q <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (accept) begin
                  case (I_Cmd_Op)
                     OP_BEGIN: begin
                        err_q    <= 1'b1;
                        type_q   <= I_PrimType;
                        idx_q    <= 2'd0;
                        primed_q <= 1'b0;
                     end
                     OP_VERTEX: begin
                        if (done_d) begin
                           if (primed_q || idx_q == 2'd2) begin
                              v1_q <= slot_q[0];
                              v2_q <= slot_q[1];
                              v3_q <= I_Vertex;
                           end else if (idx_q == 2'd1) begin
                              v1_q <= slot_q[0];
                              v2_q <= I_Vertex;
                              v3_q <= '0;
                           end else begin
                              v1_q <= I_Vertex;
                              v2_q <= '0;
                              v3_q <= '0;
                           end
                           // Strips keep the last two vertices for the next triangle.
                           if (type_q == 2'd3) begin
                              slot_q[0] <= slot_q[1];
                              slot_q[1] <= I_Vertex;
                              primed_q  <= 1'b1;
                           end
                           otype_q <= type_q;
                           valid_q <= 1'b1;
                           idx_q   <= 2'd0;
                           state_q <= ISSUE;
                        end else begin
                           slot_q[idx_q[0]] <= I_Vertex;
                           idx_q            <= idx_d;
                        end
                     end
                     OP_END: begin
                        if (idx_q != 2'd0) err_q <= 1'b1;
                        idx_q    <= 2'd0;
                        primed_q <= 1'b0;
                        state_q  <= IDLE;
                     end
                     default: ;
                  endcase
               end
            end
            ISSUE: begin
               if (!I_GPUStallSignal) begin
                  valid_q      <= 1'b0;
                  prim_count_q <= prim_count_q + 16'd1;
                  state_q      <= COLLECT;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign O_Prim_Valid = valid_q;
   assign O_VertexV1   = v1_q;
   assign O_VertexV2   = v2_q;
   assign O_VertexV3   = v3_q;
   assign O_PrimType   = otype_q;
   assign O_Error      = err_q;
   assign O_PrimCount  = prim_count_q;

endmodule

// File: tb/tb_prim_assembly_ctrl.sv
// Self-checking bench for prim_assembly_ctrl: expected primitives are queued as
// commands are driven and compared when O_Prim_Valid first appears.
module tb_prim_assembly_ctrl;

   localparam int VTX_W = 30;

   logic             I_CLOCK, I_RESET_N, I_Cmd_Valid, I_GPUStallSignal;
   logic [1:0]       I_Cmd_Op, I_PrimType;
   logic [VTX_W-1:0] I_Vertex;
   logic             O_Cmd_Ready, O_Prim_Valid, O_Error;
   logic [VTX_W-1:0] O_VertexV1, O_VertexV2, O_VertexV3;
   logic [1:0]       O_PrimType;
   logic [15:0]      O_PrimCount;

   prim_assembly_ctrl #(.VTX_W(VTX_W)) dut (
      .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_Cmd_Valid(I_Cmd_Valid),
      .I_Cmd_Op(I_Cmd_Op), .I_PrimType(I_PrimType), .I_Vertex(I_Vertex),
      .I_GPUStallSignal(I_GPUStallSignal), .O_Cmd_Ready(O_Cmd_Ready),
      .O_Prim_Valid(O_Prim_Valid), .O_VertexV1(O_VertexV1), .O_VertexV2(O_VertexV2),
      .O_VertexV3(O_VertexV3), .O_PrimType(O_PrimType), .O_Error(O_Error),
      .O_PrimCount(O_PrimCount)
   );

   initial I_CLOCK = 1'b0;
   always #5 I_CLOCK = ~I_CLOCK;

   typedef struct packed {
      logic [1:0]       t;
      logic [VTX_W-1:0] a, b, c;
   } prim_t;

   prim_t       sb[$];
   int          errors = 0;
   int          checks = 0;
   int          err_pulses = 0;
   int          prims_seen = 0;
   bit          held = 0;
   logic [15:0] exp_count = 16'd0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Outputs change on the falling edge; sample them on the rising edge.
   always @(posedge I_CLOCK) begin
      if (O_Error) err_pulses++;
      if (!O_Prim_Valid) begin
         held = 0;
      end else if (!held) begin
         prim_t e;
         held = 1;
         prims_seen++;
         if (sb.size() == 0) begin
            check_eq("prim_unexpected", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check_eq("prim_type", 64'(O_PrimType), 64'(e.t));
            check_eq("prim_v1", 64'(O_VertexV1), 64'(e.a));
            check_eq("prim_v2", 64'(O_VertexV2), 64'(e.b));
            check_eq("prim_v3", 64'(O_VertexV3), 64'(e.c));
            $display("prim #%0d type=%0d v=%0h,%0h,%0h count=%0d", prims_seen,
                     O_PrimType, O_VertexV1, O_VertexV2, O_VertexV3, O_PrimCount);
         end
      end
   end

   task automatic push_exp(input logic [1:0] t, input logic [VTX_W-1:0] a,
                           input logic [VTX_W-1:0] b, input logic [VTX_W-1:0] c);
      prim_t e;
      e.t = t; e.a = a; e.b = b; e.c = c;
      sb.push_back(e);
   endtask

   task automatic cmd(input logic [1:0] op, input logic [1:0] pt, input logic [VTX_W-1:0] v);
      int n;
      n = 0;
      @(posedge I_CLOCK);
      while (!O_Cmd_Ready && n < 50) begin
         @(posedge I_CLOCK);
         n++;
      end
      if (n >= 50) check_eq("ready_timeout", 64'd0, 64'd1);
      I_Cmd_Valid = 1'b1;
      I_Cmd_Op    = op;
      I_PrimType  = pt;
      I_Vertex    = v;
      @(negedge I_CLOCK);
      #1 I_Cmd_Valid = 1'b0;
   endtask

   task automatic issue_now();
      @(posedge I_CLOCK);
      check_eq("valid_latency", 64'(O_Prim_Valid), 64'd1);
      check_eq("ready_in_issue", 64'(O_Cmd_Ready), 64'd0);
      @(posedge I_CLOCK);
      exp_count = exp_count + 16'd1;
      check_eq("valid_drop", 64'(O_Prim_Valid), 64'd0);
      check_eq("prim_count", 64'(O_PrimCount), 64'(exp_count));
   endtask

   logic [VTX_W-1:0] va, vb, vc, vd, ve;
   int               e0;

   initial begin
      I_RESET_N = 1'b0; I_Cmd_Valid = 1'b0; I_Cmd_Op = 2'b00; I_PrimType = 2'd0;
      I_Vertex = '0; I_GPUStallSignal = 1'b0;
      va = VTX_W'($urandom); vb = VTX_W'($urandom); vc = VTX_W'($urandom);
      vd = VTX_W'($urandom); ve = VTX_W'($urandom);
      repeat (3) @(posedge I_CLOCK);
      check_eq("rst_valid", 64'(O_Prim_Valid), 64'd0);
      check_eq("rst_count", 64'(O_PrimCount), 64'd0);
      check_eq("rst_error", 64'(O_Error), 64'd0);
      check_eq("rst_ready", 64'(O_Cmd_Ready), 64'd1);
      check_eq("rst_v1", 64'(O_VertexV1), 64'd0);
      I_RESET_N = 1'b1;

      // Triangle with no stall
      cmd(2'b01, 2'd2, '0);
      cmd(2'b10, 2'd0, va);
      cmd(2'b10, 2'd0, vb);
      push_exp(2'd2, va, vb, vc);
      cmd(2'b10, 2'd0, vc);
      issue_now();

      // Triangle held by a four-cycle stall
      cmd(2'b10, 2'd0, vd);
      cmd(2'b10, 2'd0, ve);
      push_exp(2'd2, vd, ve, va);
      I_GPUStallSignal = 1'b1;
      cmd(2'b10, 2'd0, va);
      for (int i = 0; i < 5; i++) begin
         @(posedge I_CLOCK);
         check_eq("stall_valid", 64'(O_Prim_Valid), 64'd1);
         check_eq("stall_ready", 64'(O_Cmd_Ready), 64'd0);
         check_eq("stall_v2", 64'(O_VertexV2), 64'(ve));
         check_eq("stall_count", 64'(O_PrimCount), 64'(exp_count));
         if (i == 4) I_GPUStallSignal = 1'b0;
      end
      @(posedge I_CLOCK);
      exp_count = exp_count + 16'd1;
      check_eq("stall_release", 64'(O_Prim_Valid), 64'd0);
      check_eq("stall_count_inc", 64'(O_PrimCount), 64'(exp_count));
      e0 = err_pulses;
      cmd(2'b11, 2'd0, '0);
      repeat (2) @(posedge I_CLOCK);
      check_eq("end_clean_err", 64'(err_pulses - e0), 64'd0);

      // Triangle strip of five vertices
      e0 = err_pulses;
      cmd(2'b01, 2'd3, '0);
      cmd(2'b10, 2'd0, va);
      cmd(2'b10, 2'd0, vb);
      push_exp(2'd3, va, vb, vc);
      cmd(2'b10, 2'd0, vc);
      issue_now();
      push_exp(2'd3, vb, vc, vd);
      cmd(2'b10, 2'd0, vd);
      issue_now();
      push_exp(2'd3, vc, vd, ve);
      cmd(2'b10, 2'd0, ve);
      issue_now();
      cmd(2'b11, 2'd0, '0);
      repeat (2) @(posedge I_CLOCK);
      check_eq("strip_end_err", 64'(err_pulses - e0), 64'd0);
      check_eq("strip_idle", 64'(O_Cmd_Ready), 64'd1);

      // Line, then protocol errors
      cmd(2'b01, 2'd1, '0);
      cmd(2'b10, 2'd0, vb);
      push_exp(2'd1, vb, ve, '0);
      cmd(2'b10, 2'd0, ve);
      issue_now();
      cmd(2'b11, 2'd0, '0);
      e0 = err_pulses;
      cmd(2'b10, 2'd0, va);
      @(posedge I_CLOCK);
      check_eq("idle_vertex_err", 64'(O_Error), 64'd1);
      @(posedge I_CLOCK);
      check_eq("err_one_cycle", 64'(O_Error), 64'd0);
      check_eq("err_pulses_1", 64'(err_pulses - e0), 64'd1);
      cmd(2'b01, 2'd1, '0);
      cmd(2'b10, 2'd0, va);
      cmd(2'b11, 2'd0, '0);
      @(posedge I_CLOCK);
      check_eq("partial_end_err", 64'(O_Error), 64'd1);
      check_eq("partial_no_prim", 64'(O_Prim_Valid), 64'd0);
      cmd(2'b01, 2'd1, '0);
      cmd(2'b10, 2'd0, vc);
      cmd(2'b01, 2'd0, '0);
      @(posedge I_CLOCK);
      check_eq("begin_in_collect_err", 64'(O_Error), 64'd1);
      push_exp(2'd0, vd, '0, '0);
      cmd(2'b10, 2'd0, vd);
      issue_now();
      repeat (2) @(posedge I_CLOCK);
      check_eq("err_pulses_3", 64'(err_pulses - e0), 64'd3);

      // Reset while a primitive is pending
      push_exp(2'd0, ve, '0, '0);
      I_GPUStallSignal = 1'b1;
      cmd(2'b10, 2'd0, ve);
      @(posedge I_CLOCK);
      check_eq("pending_valid", 64'(O_Prim_Valid), 64'd1);
      I_RESET_N = 1'b0;
      I_Cmd_Valid = 1'b1; I_Cmd_Op = 2'b01;
      @(posedge I_CLOCK);
      exp_count = 16'd0;
      check_eq("rstmid_valid", 64'(O_Prim_Valid), 64'd0);
      check_eq("rstmid_v1", 64'(O_VertexV1), 64'd0);
      check_eq("rstmid_type", 64'(O_PrimType), 64'd0);
      check_eq("rstmid_count", 64'(O_PrimCount), 64'd0);
      check_eq("rstmid_idle", 64'(O_Cmd_Ready), 64'd1);
      I_Cmd_Valid = 1'b0; I_GPUStallSignal = 1'b0; I_RESET_N = 1'b1;

      // Counter wrap from 0xFFFF
      @(posedge I_CLOCK);
      dut.prim_count_q = 16'hFFFF;
      exp_count = 16'hFFFF;
      cmd(2'b01, 2'd0, '0);
      push_exp(2'd0, vc, '0, '0);
      cmd(2'b10, 2'd0, vc);
      issue_now();
      check_eq("wrap_zero", 64'(O_PrimCount), 64'd0);

      repeat (3) @(posedge I_CLOCK);
      check_eq("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
